ysyx_22050550_pcu: RTL and testbench
====================================

YSYX_22050550_PCU -- requirements
Module: ysyx_22050550_pcu

Interface
REQ-001: Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the PC loaded on reset.
REQ-002: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: redirect_valid  input  1  the PC SHALL be replaced by redirect_pc this cycle (branch/jump/trap/mret).
REQ-005: redirect_pc  input  64  the redirect target.
REQ-006: imem_req  output  1  instruction fetch request.
REQ-007: imem_addr  output  64  fetch address.
REQ-008: imem_gnt  input  1  request accepted by instruction memory.
REQ-009: imem_rvalid  input  1  fetch data valid.
REQ-010: imem_rdata  input  32  fetched instruction.
REQ-011: out_valid  output  1  pc/instruction pair valid toward IFU.
REQ-012: out_pc  output  64  PC of the held instruction (drives IFU pc).
REQ-013: out_inst  output  32  held instruction (drives IFU rom_inst).
REQ-014: out_ready  input  1  downstream accepts the pair.

Function
REQ-015: The FSM SHALL have four states: IDLE, REQ, WAIT, HOLD; plus registers pc_q (64), inst_q (32) and kill_q (1).
REQ-016: IDLE SHALL move to REQ unconditionally on the first clock edge after reset deassertion.
REQ-017: In REQ, imem_req=1 and imem_addr=pc_q; on imem_gnt=1, next state SHALL be WAIT.
REQ-018: In REQ without imem_gnt, imem_addr SHALL remain stable unless a redirect occurs; a redirect SHALL load pc_q and keep state REQ.
REQ-019: In REQ with imem_gnt and redirect_valid together, the grant SHALL complete with the old address, kill_q SHALL be set, pc_q SHALL load redirect_pc, and next state SHALL be WAIT.
REQ-020: In WAIT without imem_rvalid, a redirect SHALL set kill_q and load pc_q.
REQ-021: In WAIT, on imem_rvalid with kill_q=0 and no redirect, inst_q SHALL capture imem_rdata and next state SHALL be HOLD.
REQ-022: In WAIT, on imem_rvalid with kill_q=1 or a redirect, the data SHALL be discarded, kill_q cleared, any redirect applied to pc_q, and next state SHALL be REQ.
REQ-023: In HOLD, out_valid=1, out_pc=pc_q and out_inst=inst_q, and these SHALL remain stable until out_ready=1 or a redirect.
REQ-024: In HOLD with out_ready=1 and no redirect, pc_q SHALL become pc_q+4 (modulo 2^64, wrap from all-ones-minus-3 to 0) and next state SHALL be REQ.
REQ-025: In HOLD with a redirect, pc_q SHALL load redirect_pc and next state SHALL be REQ; the redirect wins over out_ready, and the same-cycle transfer still counts as delivered downstream.
REQ-026: out_valid SHALL be 0 in all states except HOLD; imem_req SHALL be 0 in all states except REQ.
REQ-027: redirect_pc[1:0] SHALL be forced to 2'b00 when loaded; compressed instructions are not supported.
REQ-028: imem_rvalid outside WAIT SHALL be ignored.
REQ-029: Best-case latency from entering REQ to out_valid=1 SHALL be 2 cycles (gnt in REQ, rvalid in the first WAIT cycle); peak throughput is one instruction per 3 cycles.
REQ-030: A redirect in IDLE SHALL load pc_q, and the block SHALL still proceed to REQ.

Reset
REQ-031: Asserting rst SHALL immediately force: state=IDLE, pc_q=RESET_PC, inst_q=0, kill_q=0, out_valid=0, imem_req=0, imem_addr=RESET_PC, out_pc=RESET_PC, out_inst=0.
REQ-032: Reset mid-transaction SHALL abandon it; any imem_rvalid after reset release and before the next grant SHALL be ignored per REQ-028.

Structure
REQ-033: The shared define file SHALL hold RESET_PC, the PC/instruction bus widths, and the FSM state encoding.
REQ-034: pc_q and inst_q SHALL be instances of one sub-module, ysyx_22050550_Reg: a parameterised width and reset value register with write enable and asynchronous reset.

Verification
REQ-035: Reset release, gnt and rvalid immediate, imem_rdata=32'h00000413, out_ready=1 -> out_valid with out_pc=0x80000000, then the next request at 0x80000004.
REQ-036: out_ready=0 for 5 cycles in HOLD -> out_pc/out_inst stable, no imem_req; out_ready=1 -> next fetch at +4.
REQ-037: Redirect to 0x80000102 while in WAIT, then rvalid -> data dropped, no out_valid, next imem_addr=0x80000100.
REQ-038: Simultaneous gnt+redirect(0x80001000) in REQ -> returned data discarded, next request at 0x80001000.
REQ-039: pc_q=64'hFFFF_FFFF_FFFF_FFFC, accept -> next imem_addr=0; async rst mid-WAIT -> outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ysyx_22050550_pcu_pkg.sv
// Shared constants and the FSM state encoding for the PC unit.
package ysyx_22050550_pcu_pkg;

  localparam int unsigned PcWidth   = 64;
  localparam int unsigned InstWidth = 32;

  // Default boot PC for the fetch front end.
  localparam logic [PcWidth-1:0] PcuResetPc = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } pcu_state_e;

endpackage

// File: rtl/ysyx_22050550_pcu_if.sv
// Redirect, instruction-memory and IFU-side signals of the PC unit.
interface ysyx_22050550_pcu_if;
  import ysyx_22050550_pcu_pkg::*;

  logic                 redirect_valid;
  logic [PcWidth-1:0]   redirect_pc;
  logic                 imem_req;
  logic [PcWidth-1:0]   imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [InstWidth-1:0] imem_rdata;
  logic                 out_valid;
  logic [PcWidth-1:0]   out_pc;
  logic [InstWidth-1:0] out_inst;
  logic                 out_ready;

  // PC unit side.
  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_inst
  );

  // Environment side (memory, redirect source, IFU).
  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/ysyx_22050550_Reg.sv
// Width/reset-value parameterised register with write enable and async reset.
module ysyx_22050550_Reg #(
  parameter int unsigned       Width    = 32,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] val_q;

  // Hold value; load d_i when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= ResetVal;
    end else if (we_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/ysyx_22050550_pcu.sv
// PC unit: fetches one instruction at a time and hands the pc/inst pair to the IFU.
module ysyx_22050550_pcu
  import ysyx_22050550_pcu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PcuResetPc
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22050550_pcu_if.master  bus_io
);

  pcu_state_e           state_q, state_d;
  logic                 kill_q, kill_d;
  logic                 pc_we;
  logic [PcWidth-1:0]   pc_d, pc_q;
  logic                 inst_we;
  logic [InstWidth-1:0] inst_q;
  logic [PcWidth-1:0]   redir_pc;
  logic                 req;
  logic                 valid;

  // Only word-aligned targets; compressed instructions are not supported.
  assign redir_pc = bus_io.redirect_pc & ~64'h3;

  ysyx_22050550_Reg #(
    .Width    (PcWidth),
    .ResetVal (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .we_i (pc_we),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  ysyx_22050550_Reg #(
    .Width    (InstWidth),
    .ResetVal ('0)
  ) u_inst_reg (
    .clk  (clk),
    .rst  (rst),
    .we_i (inst_we),
    .d_i  (bus_io.imem_rdata),
    .q_o  (inst_q)
  );

  // State and kill-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Next-state, pc/inst update and handshake outputs.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_we   = 1'b0;
    pc_d    = pc_q;
    inst_we = 1'b0;
    req     = 1'b0;
    valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (bus_io.redirect_valid) begin
          pc_we = 1'b1;
          pc_d  = redir_pc;
        end
      end

      StReq: begin
        req = 1'b1;
        if (bus_io.imem_gnt) begin
          state_d = StWait;
          // The granted fetch used the old address, so its data must be dropped.
          if (bus_io.redirect_valid) kill_d = 1'b1;
        end
        if (bus_io.redirect_valid) begin
          pc_we = 1'b1;
          pc_d  = redir_pc;
        end
      end

      StWait: begin
        if (bus_io.imem_rvalid) begin
          if (kill_q || bus_io.redirect_valid) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_we = 1'b1;
            state_d = StHold;
          end
        end else if (bus_io.redirect_valid) begin
          kill_d = 1'b1;
        end
        if (bus_io.redirect_valid) begin
          pc_we = 1'b1;
          pc_d  = redir_pc;
        end
      end

      StHold: begin
        valid = 1'b1;
        if (bus_io.redirect_valid) begin
          pc_we   = 1'b1;
          pc_d    = redir_pc;
          state_d = StReq;
        end else if (bus_io.out_ready) begin
          pc_we   = 1'b1;
          pc_d    = pc_q + 64'd4;
          state_d = StReq;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus_io.imem_req  = req;
  assign bus_io.imem_addr = pc_q;
  assign bus_io.out_valid = valid;
  assign bus_io.out_pc    = pc_q;
  assign bus_io.out_inst  = inst_q;

endmodule

// File: tb/tb_ysyx_22050550_pcu.sv
// Directed bench for the PC unit with a queue-based scoreboard.
module tb_ysyx_22050550_pcu;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [63:0] exp_fetch[$];
  logic [95:0] exp_out[$];

  ysyx_22050550_pcu_if bus ();

  ysyx_22050550_pcu #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every granted fetch address and every delivered pair.
  always @(negedge clk) begin
    if (!rst && bus.imem_req && bus.imem_gnt) begin
      if (exp_fetch.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_unexpected: got addr %h expected none", bus.imem_addr);
      end else begin
        chk("fetch_addr", bus.imem_addr, exp_fetch.pop_front());
      end
    end
    if (!rst && bus.out_valid && (bus.out_ready || bus.redirect_valid)) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got pc %h inst %h expected none",
                 bus.out_pc, bus.out_inst);
      end else begin
        logic [95:0] e;
        e = exp_out.pop_front();
        chk("out_pc", bus.out_pc, e[95:32]);
        chk("out_inst", {32'd0, bus.out_inst}, {32'd0, e[31:0]});
      end
    end
  end

  // From REQ: grant at addr, return data next cycle; ends in HOLD.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data);
    exp_fetch.push_back(addr);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    step();
    bus.imem_rvalid = 1'b0;
  endtask

  // From HOLD: accept the pair; ends in REQ.
  task automatic accept(input logic [63:0] pc, input logic [31:0] inst);
    exp_out.push_back({pc, inst});
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {63'd0, bus.imem_req}, 64'd0);
    chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_addr"}, bus.imem_addr, ResetPc);
    chk({tag, "_pc"}, bus.out_pc, ResetPc);
    chk({tag, "_inst"}, {32'd0, bus.out_inst}, 64'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.out_ready      = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");

    // Basic fetch and accept, then next request at +4.
    rst = 1'b0;
    step();
    chk("req_after_reset", {63'd0, bus.imem_req}, 64'd1);
    do_fetch(64'h8000_0000, 32'h0000_0413);
    chk("first_valid", {63'd0, bus.out_valid}, 64'd1);
    accept(64'h8000_0000, 32'h0000_0413);
    chk("next_addr", bus.imem_addr, 64'h8000_0004);

    // Downstream stall for 5 cycles in HOLD.
    do_fetch(64'h8000_0004, 32'h0010_0093);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stall_pc", bus.out_pc, 64'h8000_0004);
      chk("stall_inst", {32'd0, bus.out_inst}, 64'h0010_0093);
      chk("stall_noreq", {63'd0, bus.imem_req}, 64'd0);
      step();
    end
    accept(64'h8000_0004, 32'h0010_0093);

    // Redirect while waiting: returned data is dropped.
    exp_fetch.push_back(64'h8000_0008);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0102;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'h1111_1111;
    step();
    bus.imem_rvalid = 1'b0;
    chk("drop_wait_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("drop_wait_addr", bus.imem_addr, 64'h8000_0100);
    do_fetch(64'h8000_0100, 32'h0020_0113);
    accept(64'h8000_0100, 32'h0020_0113);

    // Grant and redirect together in REQ.
    exp_fetch.push_back(64'h8000_0104);
    bus.imem_gnt       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    step();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    chk("drop_gnt_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("drop_gnt_addr", bus.imem_addr, 64'h8000_1000);
    do_fetch(64'h8000_1000, 32'h0030_0193);

    // Redirect in HOLD wins over out_ready=0 and counts as delivered.
    exp_out.push_back({64'h8000_1000, 32'h0030_0193});
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2000;
    step();
    bus.redirect_valid = 1'b0;
    chk("hold_redir_addr", bus.imem_addr, 64'h8000_2000);

    // Redirect in REQ without grant; low bits forced to zero; then wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    chk("align_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0213);
    accept(64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0213);
    chk("wrap_addr", bus.imem_addr, 64'd0);

    // Async reset in the middle of WAIT.
    exp_fetch.push_back(64'd0);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    step();
    // Release; redirect in IDLE; stale rvalid must be ignored.
    rst = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_3000;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'h2222_2222;
    step();
    bus.redirect_valid = 1'b0;
    step();
    bus.imem_rvalid = 1'b0;
    chk("stale_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("stale_req", {63'd0, bus.imem_req}, 64'd1);
    chk("idle_redir_addr", bus.imem_addr, 64'h8000_3000);
    do_fetch(64'h8000_3000, 32'h0050_0293);
    accept(64'h8000_3000, 32'h0050_0293);
    step();

    chk("fetch_queue_empty", 64'(exp_fetch.size()), 64'd0);
    chk("out_queue_empty", 64'(exp_out.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
